// File: rtl/hamming_pair_engine_if.sv
// Purpose : bundles the start/done handshake, the byte-wide data memory bus
//           and the result ports of hamming_pair_engine.
// Signals : start/done      request / acknowledge handshake
//           mem_addr/mem_rdata/mem_we/mem_wdata  synchronous-read byte memory
//           min_dist/max_dist/min_pair/max_pair  running and final results
// Modports: master = the engine, slave = the environment (controller + memory).
interface hamming_pair_engine_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [4:0]        min_dist;
   logic [4:0]        max_dist;
   logic [9:0]        min_pair;
   logic [9:0]        max_pair;

   modport master (
      input  start, mem_rdata,
      output done, mem_addr, mem_we, mem_wdata,
      output min_dist, max_dist, min_pair, max_pair
   );

   modport slave (
      output start, mem_rdata,
      input  done, mem_addr, mem_we, mem_wdata,
      input  min_dist, max_dist, min_pair, max_pair
   );
endinterface

// File: rtl/hamming_pair_engine.sv
// Purpose : loads N_WORDS 16-bit operands from data memory bytes [0:2*N_WORDS-1]
//           (even byte = MSB), finds the minimum and maximum Hamming distance
//           over all unordered pairs, and writes them to MIN_ADDR / MAX_ADDR.
// Ports   : clk    - single clock, rising edge
//           rst_n  - synchronous active-low reset
//           bus    - hamming_pair_engine_if.master (handshake, memory, results)
// Handshake: start must be seen high once (armed) before a low start launches
//           a run; done is held in DONE until start is seen high again.
module hamming_pair_engine #(
   parameter int unsigned N_WORDS  = 32,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned MIN_ADDR = 64,
   parameter int unsigned MAX_ADDR = 65
) (
   input  logic                  clk,
   input  logic                  rst_n,
   hamming_pair_engine_if.master bus
);
   localparam int unsigned N_BYTES = 2 * N_WORDS;
   localparam int unsigned LCNT_W  = $clog2(N_BYTES + 1);
   localparam int unsigned BIDX_W  = $clog2(N_BYTES);

   typedef enum logic [2:0] {IDLE, LOAD, CMP, WMIN, WMAX, DONE} state_t;

   state_t              state, state_nx;
   logic                armed;
   logic [LCNT_W-1:0]   lcnt;
   logic [BIDX_W-1:0]   bidx;
   logic [4:0]          j, k;
   logic [15:0]         ops [N_WORDS];
   logic [4:0]          d;
   logic [4:0]          min_q, max_q;
   logic [9:0]          min_pair_q, max_pair_q;
   logic                launch, load_last, cmp_last;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int unsigned i = 0; i < 16; i++) n = n + {4'b0, v[i]};
      return n;
   endfunction

   assign launch    = armed & ~bus.start;
   assign load_last = (lcnt == LCNT_W'(N_BYTES));
   assign cmp_last  = (j == 5'(N_WORDS - 2)) && (k == 5'(N_WORDS - 1));
   // Byte captured this cycle is the one addressed on the previous cycle.
   assign bidx      = BIDX_W'(lcnt - LCNT_W'(1));
   assign d         = popcount16(ops[j] ^ ops[k]);

   assign bus.min_dist = min_q;
   assign bus.max_dist = max_q;
   assign bus.min_pair = min_pair_q;
   assign bus.max_pair = max_pair_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.done      = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: if (launch) state_nx = LOAD;
         LOAD: begin
            // The final LOAD cycle only drains the last read byte.
            if (!load_last) bus.mem_addr = ADDR_W'(lcnt);
            else            state_nx     = CMP;
         end
         CMP:  if (cmp_last) state_nx = WMIN;
         WMIN: begin
            bus.mem_addr  = ADDR_W'(MIN_ADDR);
            bus.mem_wdata = {3'b0, min_q};
            bus.mem_we    = 1'b1;
            state_nx      = WMAX;
         end
         WMAX: begin
            bus.mem_addr  = ADDR_W'(MAX_ADDR);
            bus.mem_wdata = {3'b0, max_q};
            bus.mem_we    = 1'b1;
            state_nx      = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            if (bus.start) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed      <= 1'b0;
         lcnt       <= '0;
         j          <= '0;
         k          <= 5'd1;
         min_q      <= 5'd16;
         max_q      <= '0;
         min_pair_q <= '0;
         max_pair_q <= '0;
      end else begin
         armed <= armed | bus.start;
         case (state)
            IDLE: if (launch) begin
               armed      <= 1'b0;
               lcnt       <= '0;
               j          <= '0;
               k          <= 5'd1;
               min_q      <= 5'd16;
               max_q      <= '0;
               min_pair_q <= '0;
               max_pair_q <= '0;
            end
            LOAD: lcnt <= lcnt + LCNT_W'(1);
            CMP: begin
               // Strict compares: ties keep the earliest pair in scan order.
               if (d < min_q) begin
                  min_q      <= d;
                  min_pair_q <= {j, k};
               end
               if (d > max_q) begin
                  max_q      <= d;
                  max_pair_q <= {j, k};
               end
               if (k == 5'(N_WORDS - 1)) begin
                  j <= j + 5'd1;
                  k <= j + 5'd2;
               end else begin
                  k <= k + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Operand file: plain storage, every entry rewritten on each run.
   always_ff @(posedge clk) begin
      if (state == LOAD && lcnt != '0) begin
         if (!bidx[0]) ops[bidx[BIDX_W-1:1]][15:8] <= bus.mem_rdata;
         else          ops[bidx[BIDX_W-1:1]][7:0]  <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_hamming_pair_engine.sv
module tb_hamming_pair_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   hamming_pair_engine_if #(.ADDR_W(8)) bus ();

   hamming_pair_engine #(
      .N_WORDS(32), .ADDR_W(8), .MIN_ADDR(64), .MAX_ADDR(65)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   typedef struct {
      int launch;
      int mn;
      int mx;
      int mnp;
      int mxp;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: all unordered pairs, strict min/max, pair index = j*32+k.
   function automatic exp_t model(input int launch);
      exp_t e;
      logic [15:0] w [32];
      int dd;
      for (int i = 0; i < 32; i++) w[i] = {mem[2*i], mem[2*i+1]};
      e.launch = launch; e.mn = 16; e.mx = 0; e.mnp = 0; e.mxp = 0;
      for (int a = 0; a < 32; a++)
         for (int b = a + 1; b < 32; b++) begin
            dd = $countones(w[a] ^ w[b]);
            if (dd < e.mn) begin e.mn = dd; e.mnp = a * 32 + b; end
            if (dd > e.mx) begin e.mx = dd; e.mxp = a * 32 + b; end
         end
      return e;
   endfunction

   // Monitor: scoreboard check on every rising done.
   initial begin
      bit done_q;
      int wlog[$];
      exp_t e;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) wlog.delete();
         if (bus.mem_we) begin
            wr_cnt++;
            wlog.push_back(int'(bus.mem_addr));
            if (bus.mem_addr < 8'd64) begin
               checks++; errors++;
               $display("FAIL operand_area_write: addr %0d written", bus.mem_addr);
            end
         end
         if (bus.done && !done_q) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: done rose with no run pending at t=%0t", $time);
            end else begin
               e = sbq.pop_front();
               check("latency",  cyc - e.launch, 563);
               check("min_dist", int'(bus.min_dist), e.mn);
               check("max_dist", int'(bus.max_dist), e.mx);
               check("min_pair", int'(bus.min_pair), e.mnp);
               check("max_pair", int'(bus.max_pair), e.mxp);
               check("mem64",    int'(mem[64]), e.mn);
               check("mem65",    int'(mem[65]), e.mx);
               check("write_count", wlog.size(), 2);
               if (wlog.size() >= 2) begin
                  check("write0_addr", wlog[0], 64);
                  check("write1_addr", wlog[1], 65);
               end
            end
            wlog.delete();
         end
         done_q = bus.done;
      end
   end

   task automatic fill(input int mode);
      for (int i = 0; i < 64; i++) mem[i] = (mode == 0) ? 8'h00 : 8'($urandom);
      if (mode == 1) begin
         for (int i = 0; i < 64; i++) mem[i] = 8'h00;
         mem[2] = 8'hFF; mem[3] = 8'hFF;
      end
      mem[64] = 8'hAA; mem[65] = 8'hAA;
   endtask

   task automatic launch_run(input bit expect_done, output exp_t e);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      e = model(cyc + 1);
      if (expect_done) sbq.push_back(e);
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.done) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL done_timeout: done 0 after 2000 cycles, expected 1");
      end
   endtask

   task automatic run_and_ack(input int mode);
      exp_t e;
      bit ok;
      fill(mode);
      launch_run(1'b1, e);
      wait_done(ok);
      repeat (3) @(negedge clk);
      check("done_held", int'(bus.done), 1);
      check("min_held", int'(bus.min_dist), e.mn);
      check("max_pair_held", int'(bus.max_pair), e.mxp);
      bus.start = 1'b1;
      @(negedge clk);
      check("done_falls", int'(bus.done), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_done"},     int'(bus.done), 0);
      check({tag, "_mem_we"},   int'(bus.mem_we), 0);
      check({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
      check({tag, "_wdata"},    int'(bus.mem_wdata), 0);
      check({tag, "_min"},      int'(bus.min_dist), 16);
      check({tag, "_max"},      int'(bus.max_dist), 0);
      check({tag, "_min_pair"}, int'(bus.min_pair), 0);
      check({tag, "_max_pair"}, int'(bus.max_pair), 0);
   endtask

   initial begin
      exp_t e;
      bit ok;
      bit moved;
      int w0;
      bus.start = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Start held low since reset: never armed, never launches.
      moved = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.mem_addr != 8'd0 || bus.done || bus.mem_we) moved = 1'b1;
      end
      check("no_launch_unarmed", int'(moved), 0);

      run_and_ack(0);                 // all zeros
      run_and_ack(1);                 // word1 = 0xFFFF
      repeat (3) run_and_ack(2);      // random operands

      // Reset mid-CMP: abort, no writes, no done, disarmed.
      fill(2);
      launch_run(1'b0, e);
      repeat (65 + 150) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrun_reset");
      rst_n = 1'b1;
      w0 = wr_cnt;
      moved = 1'b0;
      repeat (700) begin
         @(negedge clk);
         if (bus.done || bus.mem_addr != 8'd0) moved = 1'b1;
      end
      check("abort_no_activity", int'(moved), 0);
      check("abort_no_writes", wr_cnt - w0, 0);
      check("abort_mem65_kept", int'(mem[65]), 8'hAA);
      launch_run(1'b1, e);
      wait_done(ok);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      check("rearm_done_falls", int'(bus.done), 0);

      // Start raised mid-CMP: run completes, done is a one-cycle pulse.
      fill(2);
      launch_run(1'b1, e);
      repeat (200) @(negedge clk);
      bus.start = 1'b1;
      wait_done(ok);
      @(negedge clk);
      check("single_pulse_done", int'(bus.done), 0);
      check("single_pulse_we", int'(bus.mem_we), 0);

      // Back in IDLE: a fresh falling start launches a new run.
      fill(2);
      launch_run(1'b1, e);
      wait_done(ok);
      @(negedge clk);
      bus.start = 1'b1;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
